// File: rtl/vga_rx_monitor.sv
// Passive VGA receive-side monitor: measures line/frame timing, tracks lock,
// strobes active-region pixels with coordinates and checksums each frame.
module vga_rx_monitor #(
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned V_DISPLAY = 480,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [11:0] pixel_rgb,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_sum,
  output logic        frame_done
);

  localparam logic [11:0] H_FIRST = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_LAST  = 12'(H_SYNC + H_BP + H_DISPLAY - 1);
  localparam logic [10:0] V_FIRST = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_LAST  = 11'(V_SYNC + V_BP + V_DISPLAY - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic        r_hs, r_hs_d, r_vs, r_vs_d;
  logic [11:0] r_rgb;
  logic [1:0]  r_arm;
  logic [11:0] r_hcnt;
  logic [10:0] r_vcnt;
  logic [15:0] r_sum;
  state_t      r_state, w_state_next;
  logic        r_have_base, w_base_next;
  logic        r_h_ok, w_hok_next;
  logic        w_err_inc;

  logic        w_hs_edge, w_vs_edge;
  logic [11:0] w_hcnt_p1;
  logic [10:0] w_vcnt_p1;
  logic        w_h_mis, w_v_mis, w_sat;
  logic        w_h_act, w_v_act, w_active;
  logic        w_hok_now;
  logic [15:0] w_sum_next;

  // Input capture; r_arm keeps edge detection off until r_*_d holds a real
  // pin sample, so a release in the middle of a sync pulse is not an edge.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_hs   <= ~SYNC_POL;
      r_hs_d <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_vs_d <= ~SYNC_POL;
      r_rgb  <= '0;
      r_arm  <= '0;
    end else begin
      r_hs   <= vga_hsync;
      r_hs_d <= r_hs;
      r_vs   <= vga_vsync;
      r_vs_d <= r_vs;
      r_rgb  <= {vga_r, vga_g, vga_b};
      r_arm  <= {r_arm[0], 1'b1};
    end
  end

  assign w_hs_edge = r_arm[1] && (r_hs == SYNC_POL) && (r_hs_d != SYNC_POL);
  assign w_vs_edge = r_arm[1] && (r_vs == SYNC_POL) && (r_vs_d != SYNC_POL);

  assign w_hcnt_p1 = r_hcnt + 12'd1;
  assign w_vcnt_p1 = r_vcnt + 11'd1;
  assign w_h_mis   = w_hs_edge && (w_hcnt_p1 != h_total);
  assign w_v_mis   = w_vs_edge && (w_vcnt_p1 != v_total);
  assign w_sat     = (r_hcnt == '1) || (r_vcnt == '1);

  assign w_h_act   = (r_hcnt >= H_FIRST) && (r_hcnt <= H_LAST);
  assign w_v_act   = (r_vcnt >= V_FIRST) && (r_vcnt <= V_LAST);
  assign w_active  = w_h_act && w_v_act;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      if (w_hs_edge)
        r_hcnt <= '0;
      else if (r_hcnt != '1)
        r_hcnt <= w_hcnt_p1;

      if (w_vs_edge)
        r_vcnt <= '0;
      else if (w_hs_edge && (r_vcnt != '1))
        r_vcnt <= w_vcnt_p1;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_total <= '0;
      v_total <= '0;
    end else begin
      if (w_hs_edge)
        h_total <= w_hcnt_p1;
      if (w_vs_edge)
        v_total <= w_vcnt_p1;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
    end else begin
      pixel_valid <= w_active;
      if (w_active) begin
        pixel_x   <= 10'(r_hcnt - H_FIRST);
        pixel_y   <= 9'(r_vcnt - V_FIRST);
        pixel_rgb <= r_rgb;
      end else begin
        pixel_x   <= '0;
        pixel_y   <= '0;
        pixel_rgb <= '0;
      end
    end
  end

  // The pixel strobed on the vsync-edge cycle still belongs to the ending frame.
  assign w_sum_next = r_sum + (w_active ? {4'b0000, r_rgb} : 16'd0);

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_sum      <= '0;
      frame_sum  <= '0;
      frame_done <= 1'b0;
    end else if (w_vs_edge) begin
      frame_sum  <= w_sum_next;
      r_sum      <= '0;
      frame_done <= 1'b1;
    end else begin
      r_sum      <= w_sum_next;
      frame_done <= 1'b0;
    end
  end

  assign w_hok_now = r_h_ok && !w_h_mis;

  // MEASURE takes one vsync edge to establish a baseline v_total, then
  // locks on the next edge whose frame repeated it with all lines matching.
  always_comb begin
    w_state_next = r_state;
    w_base_next  = r_have_base;
    w_hok_next   = r_h_ok;
    w_err_inc    = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_vs_edge) begin
          w_state_next = MEASURE;
          w_base_next  = 1'b0;
          w_hok_next   = 1'b1;
        end
      end
      MEASURE: begin
        w_hok_next = w_hok_now;
        if (w_vs_edge) begin
          if (!r_have_base) begin
            w_base_next = 1'b1;
            w_hok_next  = 1'b1;
          end else if (!w_v_mis && w_hok_now) begin
            w_state_next = LOCKED;
          end else begin
            w_hok_next = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (w_h_mis || w_v_mis || w_sat) begin
          w_state_next = SEARCH;
          w_err_inc    = 1'b1;
        end
      end
      default: w_state_next = SEARCH;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_state     <= SEARCH;
      r_have_base <= 1'b0;
      r_h_ok      <= 1'b1;
      locked      <= 1'b0;
      err_cnt     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_have_base <= w_base_next;
      r_h_ok      <= w_hok_next;
      locked      <= (w_state_next == LOCKED);
      if (w_err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Randomised VGA stream against a cycle-indexed behavioural model of the monitor.
module tb_vga_rx_monitor;

  localparam int   HS  = 8;
  localparam int   HBP = 6;
  localparam int   HD  = 20;
  localparam int   LT  = 40;
  localparam int   VS  = 2;
  localparam int   VBP = 3;
  localparam int   VD  = 6;
  localparam int   FT  = 14;
  localparam logic POL = 1'b0;
  localparam int   HST = HS + HBP;
  localparam int   HEN = HS + HBP + HD - 1;
  localparam int   VST = VS + VBP;
  localparam int   VEN = VS + VBP + VD - 1;

  logic        clk, rst_n;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        pixel_valid, locked, frame_done;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [11:0] pixel_rgb, h_total;
  logic [10:0] v_total;
  logic [7:0]  err_cnt;
  logic [15:0] frame_sum;

  vga_rx_monitor #(
    .H_SYNC(HS), .H_BP(HBP), .H_DISPLAY(HD),
    .V_SYNC(VS), .V_BP(VBP), .V_DISPLAY(VD), .SYNC_POL(POL)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .h_total(h_total), .v_total(v_total),
    .locked(locked), .err_cnt(err_cnt),
    .frame_sum(frame_sum), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycle n = rising edges since reset release; edges are known from the
  // sample history, counters are "cycles/lines since the last detected edge".
  int          n, last_he, lines, sum, mst, err;
  bit          base, hok;
  logic        p1_hs, p1_vs, p2_hs, p2_vs;
  logic [11:0] p1_rgb;
  bit          e_valid, e_fd, e_locked;
  int          e_x, e_y;
  logic [11:0] e_rgb, e_ht;
  logic [10:0] e_vt;
  logic [15:0] e_fs;

  task automatic model_reset();
    n = 0; last_he = -1; lines = 0; sum = 0; mst = 0; err = 0;
    base = 0; hok = 1;
    p1_hs = ~POL; p1_vs = ~POL; p2_hs = ~POL; p2_vs = ~POL; p1_rgb = '0;
    e_valid = 0; e_fd = 0; e_locked = 0; e_x = 0; e_y = 0; e_rgb = '0;
    e_ht = '0; e_vt = '0; e_fs = '0;
  endtask

  task automatic model_step();
    int  hc, vc, pix;
    bit  he, ve, act, hm, vm, sat, hok_now;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hc  = (n - last_he - 1 > 4095) ? 4095 : n - last_he - 1;
    vc  = (lines > 2047) ? 2047 : lines;
    he  = (n >= 2) && (p1_hs == POL) && (p2_hs != POL);
    ve  = (n >= 2) && (p1_vs == POL) && (p2_vs != POL);
    act = (hc >= HST) && (hc <= HEN) && (vc >= VST) && (vc <= VEN);
    e_valid = act;
    if (act) begin
      e_x = hc - HST; e_y = vc - VST; e_rgb = p1_rgb;
    end
    hm  = he && (12'(hc + 1) != e_ht);
    vm  = ve && (11'(vc + 1) != e_vt);
    sat = (hc == 4095) || (vc == 2047);
    pix = act ? int'(p1_rgb) : 0;
    if (ve) begin
      e_fs = 16'(sum + pix); sum = 0; e_fd = 1;
    end else begin
      sum = (sum + pix) % 65536; e_fd = 0;
    end
    case (mst)
      0: if (ve) begin mst = 1; base = 0; hok = 1; end
      1: begin
        hok_now = hok && !hm;
        hok = hok_now;
        if (ve) begin
          if (!base) begin base = 1; hok = 1; end
          else if (!vm && hok_now) mst = 2;
          else hok = 1;
        end
      end
      default: if (hm || vm || sat) begin
        mst = 0;
        if (err < 255) err++;
      end
    endcase
    e_locked = (mst == 2);
    if (he) e_ht = 12'(hc + 1);
    if (ve) e_vt = 11'(vc + 1);
    if (he) last_he = n;
    if (ve) lines = 0;
    else if (he) lines++;
    p2_hs = p1_hs; p2_vs = p1_vs;
    p1_hs = vga_hsync; p1_vs = vga_vsync; p1_rgb = {vga_r, vga_g, vga_b};
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("pixel_valid", pixel_valid, e_valid);
    if (e_valid) begin
      chk("pixel_x", pixel_x, e_x);
      chk("pixel_y", pixel_y, e_y);
      chk("pixel_rgb", pixel_rgb, e_rgb);
    end
    chk("locked", locked, e_locked);
    chk("err_cnt", err_cnt, err);
    chk("h_total", h_total, e_ht);
    chk("v_total", v_total, e_vt);
    chk("frame_done", frame_done, e_fd);
    chk("frame_sum", frame_sum, e_fs);
  endtask

  // Stream generator: position (gl, gh) of the next pin sample to drive.
  int gl, gh, cur_len, pl, ph, short_at_line;
  bit rgb_const, probe_en, rand_len;

  function automatic int new_len(input int l);
    if (l == short_at_line) begin
      short_at_line = -1;
      return LT - 1;
    end
    if (rand_len && ($urandom_range(0, 3) == 0))
      return LT - 2 + int'($urandom_range(0, 4));
    return LT;
  endfunction

  task automatic step_pin();
    logic [11:0] rgb;
    vga_hsync = (gh < HS) ? POL : ~POL;
    vga_vsync = (gl < VS) ? POL : ~POL;
    rgb = rgb_const ? 12'h0F0 : 12'($urandom);
    {vga_r, vga_g, vga_b} = rgb;
    tick();
    if (probe_en && pl == 5 && ph == 15) begin
      chk("first_px_valid", pixel_valid, 1);
      chk("first_px_x", pixel_x, 0);
      chk("first_px_y", pixel_y, 0);
    end
    if (probe_en && pl == 10 && ph == 34) begin
      chk("last_px_valid", pixel_valid, 1);
      chk("last_px_x", pixel_x, 19);
      chk("last_px_y", pixel_y, 5);
    end
    pl = gl; ph = gh;
    gh++;
    if (gh >= cur_len) begin
      gh = 0;
      gl = (gl + 1) % FT;
      cur_len = new_len(gl);
    end
  endtask

  task automatic run_to_frame_start();
    for (int i = 0; i < 3 * FT * LT && !(gl == 0 && gh == 0); i++)
      step_pin();
  endtask

  task automatic run_to(input int l, input int h);
    for (int i = 0; i < 3 * FT * LT && !(gl == l && gh == h); i++)
      step_pin();
  endtask

  task automatic run_frames(input int k);
    for (int i = 0; i < k; i++) begin
      step_pin();
      run_to_frame_start();
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      vga_hsync = ~POL; vga_vsync = ~POL;
      {vga_r, vga_g, vga_b} = 12'($urandom);
      tick();
    end
    gl = 0; gh = 0; cur_len = LT;
  endtask

  initial begin
    rst_n = 1'b0;
    vga_hsync = ~POL; vga_vsync = ~POL;
    {vga_r, vga_g, vga_b} = '0;
    gl = 7; gh = 13; cur_len = LT; pl = -1; ph = -1; short_at_line = -1;
    rgb_const = 0; probe_en = 0; rand_len = 0;
    model_reset();
    #2;
    chk("reset_valid", pixel_valid, 0);
    chk("reset_locked", locked, 0);
    chk("reset_h_total", h_total, 0);
    chk("reset_frame_sum", frame_sum, 0);
    repeat (5) step_pin();
    rst_n = 1'b1;

    // Lock on the vsync edge that ends the second full frame.
    run_to_frame_start();
    run_frames(2);
    chk("prelock_locked", locked, 0);
    step_pin();
    step_pin();
    chk("lock_locked", locked, 1);
    chk("lock_h_total", h_total, 40);
    chk("lock_v_total", v_total, 14);
    chk("lock_err_cnt", err_cnt, 0);

    // Constant-colour frame checksum plus first/last pixel coordinates.
    run_to_frame_start();
    rgb_const = 1; probe_en = 1;
    run_frames(1);
    rgb_const = 0; probe_en = 0;
    step_pin();
    step_pin();
    chk("const_frame_done", frame_done, 1);
    chk("const_frame_sum", frame_sum, 16'h7080);
    step_pin();
    chk("frame_done_pulse", frame_done, 0);

    // One short line while locked, then relock after two clean frames.
    run_to_frame_start();
    short_at_line = 8;
    run_to(9, 0);
    step_pin();
    chk("short_still_locked", locked, 1);
    step_pin();
    chk("short_unlocked", locked, 0);
    chk("short_err_cnt", err_cnt, 1);
    chk("short_h_total", h_total, 39);
    run_to_frame_start();
    run_frames(2);
    chk("relock_pending", locked, 0);
    step_pin();
    step_pin();
    chk("relock_locked", locked, 1);
    chk("relock_err_cnt", err_cnt, 1);

    // Sync loss long enough to saturate the line counter.
    run_to_frame_start();
    idle(4200);
    chk("sat_unlocked", locked, 0);
    chk("sat_err_cnt", err_cnt, 2);
    run_frames(3);
    chk("sat_relock", locked, 1);

    // Jittered line lengths.
    rand_len = 1;
    run_frames(4);
    rand_len = 0;
    run_to_frame_start();
    run_frames(3);

    // Reset in the middle of an hsync pulse on an active line.
    run_to(6, 2);
    step_pin();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", pixel_valid, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_h_total", h_total, 0);
    chk("midrst_v_total", v_total, 0);
    chk("midrst_frame_sum", frame_sum, 0);
    step_pin();
    step_pin();
    rst_n = 1'b1;
    run_to(7, 0);
    chk("no_false_h_capture", h_total, 0);
    chk("no_false_v_capture", v_total, 0);
    step_pin();
    step_pin();
    run_to_frame_start();
    run_frames(2);
    step_pin();
    step_pin();
    chk("final_locked", locked, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
